// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer for the shared 8-bit ALU.
// Accepts one instruction per handshake, keeps the accumulator and carry flag,
// and runs an 8x8 multiply as eight shift-and-add iterations through the ALU.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [7:0] instr_data,
    output logic [2:0] alu_oper,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_cy,
    output logic [7:0] acc,
    output logic       cy_flag,
    output logic       res_valid,
    output logic       busy,
    output logic       err
);

    localparam int unsigned DW     = 8;
    localparam int unsigned OPW    = 4;
    localparam int unsigned ALUOPW = 3;
    localparam int unsigned CNTW   = 3;

    localparam logic [OPW-1:0]  OP_LOAD  = OPW'(8);
    localparam logic [OPW-1:0]  OP_MUL   = OPW'(9);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic              cy_q, cy_d;
    logic              err_q, err_d;
    logic [DW-1:0]     p_q, p_d;
    logic [DW-1:0]     m_q, m_d;
    logic [DW-1:0]     q_q, q_d;
    logic              ovf_q, ovf_d;
    logic              mlost_q, mlost_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    assign acc     = acc_q;
    assign cy_flag = cy_q;
    assign err     = err_q;

    // Next-state, datapath updates and ALU port drive
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        acc_d       = acc_q;
        cy_d        = cy_q;
        err_d       = err_q;
        p_d         = p_q;
        m_d         = m_q;
        q_d         = q_q;
        ovf_d       = ovf_q;
        mlost_d     = mlost_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        alu_oper    = '0;
        alu_a       = acc_q;
        alu_b       = '0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    op_d   = instr_op;
                    data_d = instr_data;
                    if (instr_op == OP_MUL) begin
                        p_d     = '0;
                        m_d     = acc_q;
                        q_d     = instr_data;
                        ovf_d   = 1'b0;
                        mlost_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_oper = op_q[ALUOPW-1:0];
                alu_b    = data_q;
                if (op_q[OPW-1] == 1'b0) begin
                    acc_d = alu_out;
                    cy_d  = alu_cy;
                end else if (op_q == OP_LOAD) begin
                    acc_d = data_q;
                    cy_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_MUL: begin
                alu_a = p_q;
                alu_b = m_q;
                if (q_q[0]) begin
                    p_d   = alu_out;
                    // a set multiplier bit after M lost a high bit means the product overflowed
                    ovf_d = ovf_q | alu_cy | mlost_q;
                end
                mlost_d = mlost_q | m_q[DW-1];
                m_d     = {m_q[DW-2:0], 1'b0};
                q_d     = {1'b0, q_q[DW-1:1]};
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST) begin
                    acc_d   = p_d;
                    cy_d    = ovf_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            err_q   <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            mlost_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            err_q   <= err_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            mlost_q <= mlost_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 8-bit ALU, table of instructions with
// expected acc/cy, scoreboard queue checked on each res_valid pulse.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [7:0] instr_data;
    logic [2:0] alu_oper;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_cy;
    logic [7:0] acc;
    logic       cy_flag;
    logic       res_valid;
    logic       busy;
    logic       err;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_data(instr_data),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_cy(alu_cy),
        .acc(acc), .cy_flag(cy_flag), .res_valid(res_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared ALU
    logic [8:0] alu_r;
    always_comb begin
        case (alu_oper)
            3'd0:    alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_r = {1'b0, alu_a} + 9'd1;
            3'd2:    alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            3'd3:    alu_r = {1'b0, alu_a} - 9'd1;
            3'd4:    alu_r = {1'b0, alu_a[6:0], 1'b0};
            3'd5:    alu_r = {2'b00, alu_a[7:1]};
            3'd6:    alu_r = {1'b0, ~(alu_a & alu_b)};
            default: alu_r = {8'h00, (alu_a > alu_b)};
        endcase
        alu_out = alu_r[7:0];
        alu_cy  = alu_r[8];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] acc;
        logic       cy;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] acc;
        logic       cy;
    } vec_t;

    // Result monitor: every res_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc", int'(acc), int'(e.acc));
                chk("cy_flag", int'(cy_flag), int'(e.cy));
                chk("err", int'(err), int'(e.err));
                chk("res_latency", cyc, e.cyc);
                chk("done_ready", int'(instr_ready), 0);
                chk("done_busy", int'(busy), 1);
            end
        end
    end

    int  last_xfer = -1;
    bit  stream_on = 1'b0;

    // Present one instruction, wait for its transfer, queue the expected result
    task automatic send(input logic [3:0] op, input logic [7:0] d,
                        input logic [7:0] ea, input logic ec, input logic ee,
                        input bit keep);
        int   n;
        int   c;
        exp_t e;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_data  = d;
        n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 0, 1);
        c = cyc;
        if (stream_on && last_xfer >= 0) chk("xfer_gap", c - last_xfer, 3);
        last_xfer = c;
        e.acc = ea;
        e.cy  = ec;
        e.err = ee;
        e.cyc = c + 1 + ((op == 4'd9) ? 8 : 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("result_timeout", 0, 1);
    endtask

    vec_t vecs[25] = '{
        '{4'd8, 8'h05, 8'h05, 1'b0},
        '{4'd0, 8'h03, 8'h08, 1'b0},
        '{4'd8, 8'h03, 8'h03, 1'b0},
        '{4'd2, 8'h05, 8'hFE, 1'b1},
        '{4'd8, 8'h00, 8'h00, 1'b0},
        '{4'd3, 8'h00, 8'hFF, 1'b1},
        '{4'd8, 8'hFF, 8'hFF, 1'b0},
        '{4'd1, 8'h00, 8'h00, 1'b1},
        '{4'd8, 8'h80, 8'h80, 1'b0},
        '{4'd0, 8'h80, 8'h00, 1'b1},
        '{4'd8, 8'h0C, 8'h0C, 1'b0},
        '{4'd9, 8'h0B, 8'h84, 1'b0},
        '{4'd8, 8'h20, 8'h20, 1'b0},
        '{4'd9, 8'h10, 8'h00, 1'b1},
        '{4'd8, 8'hFF, 8'hFF, 1'b0},
        '{4'd9, 8'h01, 8'hFF, 1'b0},
        '{4'd9, 8'hFF, 8'h01, 1'b1},
        '{4'd8, 8'h09, 8'h09, 1'b0},
        '{4'd7, 8'h04, 8'h01, 1'b0},
        '{4'd7, 8'h01, 8'h00, 1'b0},
        '{4'd8, 8'hF0, 8'hF0, 1'b0},
        '{4'd6, 8'hF0, 8'h0F, 1'b0},
        '{4'd8, 8'h81, 8'h81, 1'b0},
        '{4'd4, 8'h00, 8'h02, 1'b0},
        '{4'd5, 8'h00, 8'h01, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 4'd0;
        instr_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc", int'(acc), 0);
        chk("rst_cy", int'(cy_flag), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_alu_oper", int'(alu_oper), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        rst = 1'b0;

        // Table-driven single instructions
        for (int i = 0; i < 25; i++) begin
            send(vecs[i].op, vecs[i].data, vecs[i].acc, vecs[i].cy, 1'b0, 1'b0);
            drain();
        end

        // Illegal opcode: acc/cy untouched, err sticky through later legal ops
        send(4'd8, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0); drain();
        send(4'hC, 8'h00, 8'h42, 1'b0, 1'b1, 1'b0); drain();
        send(4'd0, 8'h01, 8'h43, 1'b0, 1'b1, 1'b0); drain();
        send(4'd9, 8'h02, 8'h86, 1'b0, 1'b1, 1'b0); drain();

        // instr_valid held high: one transfer every third cycle
        stream_on = 1'b1;
        last_xfer = -1;
        send(4'd8, 8'hFD, 8'hFD, 1'b0, 1'b1, 1'b1);
        send(4'd1, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b1);
        send(4'd1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        send(4'd1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        stream_on = 1'b0;
        drain();

        // Reset in the middle of a multiply: aborted, no result pulse
        send(4'd8, 8'h0C, 8'h0C, 1'b0, 1'b1, 1'b0); drain();
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 4'd9;
        instr_data  = 8'h0B;
        chk("mul_ready", int'(instr_ready), 1);
        c = cyc;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        while (cyc < c + 3) @(negedge clk);
        chk("mul_busy", int'(busy), 1);
        chk("mul_not_ready", int'(instr_ready), 0);
        chk("mul_alu_oper", int'(alu_oper), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_acc", int'(acc), 0);
        chk("abort_cy", int'(cy_flag), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_ready", int'(instr_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        repeat (12) @(negedge clk);
        chk("abort_no_pending", sb.size(), 0);

        // Normal operation after the abort
        send(4'd8, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0); drain();
        send(4'd9, 8'h06, 8'h2A, 1'b0, 1'b0, 1'b0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Instruction sequencer for the shared 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and drives the ALU operand and opcode ports. It keeps an 8-bit accumulator and carry flag, and adds a multi-cycle 8×8 multiply built from repeated ALU additions. It sits between an instruction source (bus or test driver) and one ALU instance, and owns that ALU's inputs exclusively.

## Interface
- No parameters; widths are fixed to the 8-bit ALU.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept this cycle
- instr_op  in  4  opcode: 0–7 ALU op (Add, Inc, Sub, Dec, SHL, SHR, NAND, A>B), 8 LOAD, 9 MUL, 10–15 illegal
- instr_data  in  8  operand B / load value / multiplier
- alu_oper  out  3  to ALU operation select
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_out  in  8  from ALU result
- alu_cy  in  1  from ALU carry/borrow
- acc  out  8  accumulator
- cy_flag  out  1  carry/overflow of last completed instruction
- res_valid  out  1  one-cycle pulse: acc/cy_flag updated
- busy  out  1  high in any state but IDLE
- err  out  1  sticky: illegal opcode received

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: instr_ready=1. Transfer occurs when instr_valid&instr_ready at a clock edge. On transfer, op and data are registered. The next state is EXEC for ops 0–8 and 10–15, and MUL for op 9.
- EXEC (1 cycle): alu_oper=op[2:0], alu_a=acc, alu_b=data.
  - Ops 0–7: acc<=alu_out, cy_flag<=alu_cy.
  - LOAD: acc<=data, cy_flag<=0.
  - Illegal ops: acc and cy_flag unchanged, err<=1.
  - Next state is DONE.
- MUL: operates on internal P (product, init 0), M (multiplicand, init acc), Q (multiplier, init data), ovf (init 0), mlost (init 0), and a 3-bit iteration counter (init 0). One iteration per cycle, 8 iterations total:
  - alu_oper=000, alu_a=P, alu_b=M.
  - If Q[0]: P<=alu_out, ovf<=ovf|alu_cy|mlost.
  - Every iteration: mlost<=mlost|M[7], M<=M<<1, Q<=Q>>1.
  - After the 8th iteration (counter wraps 7→0): acc<=final P, cy_flag<=final ovf, then go to DONE.
  - Result: acc = (acc×data) mod 256; cy_flag=1 exactly when the 16-bit product >255.
- DONE (1 cycle): res_valid=1, instr_ready=0, next state IDLE.
- Outside EXEC and MUL: alu_oper=000, alu_a=acc, alu_b=0.
- ALU width rules apply as the ALU defines them:
  - Sub and Dec return the 9-bit two's-complement difference, so CY is the borrow.
  - Inc and Add return the 9-bit carry.
  - SHL, SHR, NAND and compare always give CY=0.
- err clears only on rst.

## Timing
- Reset values: state IDLE, acc=0x00, cy_flag=0, err=0, res_valid=0, busy=0, instr_ready=1. ALU outputs take their idle values; MUL registers are 0.
- rst dominates everything. Reset during EXEC, MUL or DONE aborts the operation with no res_valid pulse. The next cycle is IDLE with reset values.
- instr_ready is combinational from state only (IDLE). It never depends on instr_valid.
- Single-cycle op accepted at edge k:
  - EXEC during cycle k+1.
  - acc and cy_flag updated at edge k+1.
  - res_valid=1 during cycle k+2, with DONE and the new acc visible.
  - IDLE at cycle k+3.
  - Maximum throughput is one instruction per 3 cycles.
- MUL accepted at edge k:
  - MUL during cycles k+1..k+8.
  - acc updated at edge k+8.
  - res_valid during cycle k+9.
  - IDLE at cycle k+10.
- busy=1 from the cycle after transfer through the DONE cycle inclusive.
- instr_valid and instr_data are ignored while instr_ready=0. The source holds them until transfer.

## Test plan
- After reset: LOAD 0x05, then Add 0x03 → acc=0x08, cy=0. res_valid pulses exactly 2 cycles after each transfer.
- LOAD 0x03, Sub 0x05 → acc=0xFE, cy=1. LOAD 0x00, Dec → acc=0xFF, cy=1. LOAD 0xFF, Inc → acc=0x00, cy=1.
- LOAD 0x0C, MUL 0x0B → acc=0x84, cy=0, res_valid 9 cycles after transfer. LOAD 0x20, MUL 0x10 → acc=0x00, cy=1. LOAD 0xFF, MUL 0x01 → acc=0xFF, cy=0.
- LOAD 0x09, compare B=0x04 → acc=0x01. Compare 0x01 → acc=0x00. NAND 0xF0 on 0xF0 → acc=0x0F.
- Opcode 0xC with acc=0x42 → err=1, acc=0x42, res_valid pulses. err stays 1 through later legal ops until rst.
- Hold instr_valid high continuously during an ops stream → exactly one transfer per IDLE cycle, none while busy. Assert rst at MUL cycle 4 → acc=0x00, no res_valid, instr_ready=1 next cycle.
